// File: rtl/nic8_pkg.sv
// Shared definitions for the NIC-8 front end: sequencer state encoding,
// default PC width and instruction-word field layout.
package nic8_pkg;

    localparam int DEFAULT_PC_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seqState_t;

    // Opcode field positions within the 8-bit instruction word.
    localparam int OP_BIT7    = 7;
    localparam int OP_DST_MSB = 6;
    localparam int OP_DST_LSB = 4;
    localparam int OP_BIT3    = 3;
    localparam int OP_SRC_MSB = 2;
    localparam int OP_SRC_LSB = 0;

    typedef struct packed {
        logic       bit7;
        logic [2:0] dest;
        logic       bit3;
        logic [2:0] source;
    } opcode_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Signals between the fetch sequencer, program ROM and instruction decoder.
// The master side is the sequencer; the slave side is its environment.
interface fetch_sequencer_if
    import nic8_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int COUNT_WIDTH = 16
);
    logic [7:0]             romData;
    logic [7:0]             bus;
    logic                   assertRom;
    logic                   doJumpBar;
    logic                   haltReq;
    logic [7:0]             ir;
    logic [PC_WIDTH-1:0]    romAddr;
    logic                   execPhase;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] retired;

    modport master (
        input  romData, bus, assertRom, doJumpBar, haltReq,
        output ir, romAddr, execPhase, halted, retired
    );

    modport slave (
        output romData, bus, assertRom, doJumpBar, haltReq,
        input  ir, romAddr, execPhase, halted, retired
    );
endinterface

// File: rtl/pc_counter.sv
// Loadable, enable-able wrapping program counter; load beats inc, and the
// asynchronous clear returns it to RESET_VALUE.
module pc_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             resetBar,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] count
);

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= loadValue;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-cycle fetch/execute sequencer: owns PC and IR, advances the PC from
// decoder hints, counts retired instructions and supports halting.
module fetch_sequencer
    import nic8_pkg::*;
#(
    parameter int                  PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  COUNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              resetBar,
    fetch_sequencer_if.master port
);

    seqState_t              state;
    seqState_t              nextState;
    opcode_t                irReg;
    logic [COUNT_WIDTH-1:0] retiredCount;
    logic [PC_WIDTH-1:0]    pc;
    logic                   pcInc;
    logic                   pcLoad;
    logic                   irLoad;
    logic                   retire;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state <= ST_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        nextState = state;
        pcInc     = 1'b0;
        pcLoad    = 1'b0;
        irLoad    = 1'b0;
        retire    = 1'b0;
        unique case (state)
            ST_FETCH: begin
                irLoad    = 1'b1;
                pcInc     = 1'b1;
                nextState = ST_EXEC;
            end
            ST_EXEC: begin
                // A jump outranks the immediate skip inside pc_counter.
                pcLoad    = !port.doJumpBar;
                pcInc     = port.assertRom;
                retire    = 1'b1;
                nextState = port.haltReq ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (!port.haltReq) begin
                    nextState = ST_FETCH;
                end
            end
            default: nextState = ST_FETCH;
        endcase
    end

    pc_counter #(
        .WIDTH       (PC_WIDTH),
        .RESET_VALUE (RESET_PC)
    ) u_pcCounter (
        .clk       (clk),
        .resetBar  (resetBar),
        .inc       (pcInc),
        .load      (pcLoad),
        .loadValue (PC_WIDTH'(port.bus)),
        .count     (pc)
    );

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            irReg <= '0;
        end else if (irLoad) begin
            irReg <= opcode_t'(port.romData);
        end
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            retiredCount <= '0;
        end else if (retire) begin
            retiredCount <= retiredCount + COUNT_WIDTH'(1);
        end
    end

    assign port.ir        = irReg;
    assign port.romAddr   = pc;
    assign port.execPhase = (state == ST_EXEC);
    assign port.halted    = (state == ST_HALT);
    assign port.retired   = retiredCount;

endmodule
